// File: rtl/baud_pkg.sv
// Shared defaults and divisor helper for the baud-rate tick generator.
package baud_pkg;

    localparam int unsigned CNT_W_DEF  = 20;
    localparam int unsigned OVS_DEF    = 16;
    localparam int unsigned FRAC_W_DEF = 4;
    localparam int unsigned OVS_W      = $clog2(OVS_DEF);

    // Works on the low two bits only so it stays width-independent:
    // a divisor of 0 or 1 (upper bits all zero) becomes 2.
    function automatic logic [1:0] clamp_div(input logic [1:0] lo, input logic hi_zero);
        return (hi_zero && !lo[1]) ? 2'b10 : lo;
    endfunction

endpackage

// File: rtl/baud_frac_acc.sv
// Fractional divisor accumulator: adds frac at each period start, reports the carry.
module baud_frac_acc
    import baud_pkg::*;
#(
    parameter int unsigned FRAC_W = FRAC_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              start_i,
    input  logic [FRAC_W-1:0] frac_i,
    output logic              carry_o
);

    logic [FRAC_W-1:0] acc_q, acc_d;
    logic [FRAC_W:0]   sum;

    always_comb begin
        sum   = {1'b0, acc_q} + {1'b0, frac_i};
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (start_i) begin
            acc_d = sum[FRAC_W-1:0];
        end
    end

    assign carry_o = start_i & sum[FRAC_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/baud_gen.sv
// Baud-rate tick generator: runtime divisor, oversample counter, bit and mid-bit ticks.
// Define BAUD_GEN_FRAC_EN to build the fractional divisor accumulator.
module baud_gen
    import baud_pkg::*;
#(
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned OVS    = OVS_DEF,
    parameter int unsigned FRAC_W = FRAC_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   restart,
    input  logic [CNT_W-1:0]       div,
    input  logic [FRAC_W-1:0]      frac,
    output logic                   ovs_tick,
    output logic                   bit_tick,
    output logic                   mid_tick,
    output logic [CNT_W-1:0]       cnt,
    output logic [$clog2(OVS)-1:0] ovs_cnt,
    output logic                   div_err
);

    localparam int unsigned OVS_B = $clog2(OVS);
    localparam logic [OVS_B-1:0] OVS_HALF = OVS_B'(OVS / 2);
    localparam logic [OVS_B-1:0] OVS_MAX  = OVS_B'(OVS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OVS_B-1:0] ovs_cnt_q, ovs_cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic             carry_q, carry_d;
    logic             started_q, started_d;
    logic             err_q, err_d;
    logic             ovs_tick_q, ovs_tick_d;
    logic             bit_tick_q, bit_tick_d;
    logic             mid_tick_q, mid_tick_d;

    logic             carry;
    logic             wrap;
    logic             start;
    logic             div_small;
    logic [CNT_W-1:0] div_clamped;
    logic [CNT_W-1:0] lim;
    logic [CNT_W-1:0] lim_m1;

    assign div_small   = ~|div[CNT_W-1:1];
    assign div_clamped = {div[CNT_W-1:2], clamp_div(div[1:0], ~|div[CNT_W-1:2])};

    // Saturate so an all-ones divisor with a carry cannot wrap to zero.
    assign lim    = (carry_q && (div_q != '1)) ? div_q + 1'b1 : div_q;
    assign lim_m1 = lim - 1'b1;

    // The first enabled cycle after reset/restart and every wrap begin a period.
    assign wrap  = en & ~restart & started_q & (cnt_q == lim_m1);
    assign start = en & ~restart & (~started_q | wrap);

`ifdef BAUD_GEN_FRAC_EN
    baud_frac_acc #(
        .FRAC_W(FRAC_W)
    ) u_frac_acc (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (restart),
        .start_i(start),
        .frac_i (frac),
        .carry_o(carry)
    );
`else
    logic unused_frac;
    assign unused_frac = ^frac;
    assign carry       = 1'b0;
`endif

    always_comb begin
        cnt_d      = cnt_q;
        ovs_cnt_d  = ovs_cnt_q;
        div_d      = div_q;
        carry_d    = carry_q;
        started_d  = started_q;
        err_d      = err_q;
        ovs_tick_d = 1'b0;
        bit_tick_d = 1'b0;
        mid_tick_d = 1'b0;

        if (restart) begin
            cnt_d     = '0;
            ovs_cnt_d = '0;
            started_d = 1'b0;
        end else if (en) begin
            started_d = 1'b1;
            if (wrap) begin
                cnt_d      = '0;
                ovs_cnt_d  = ovs_cnt_q + 1'b1;
                ovs_tick_d = 1'b1;
                bit_tick_d = (ovs_cnt_q == OVS_MAX);
                mid_tick_d = (ovs_cnt_d == OVS_HALF);
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            if (start) begin
                div_d   = div_clamped;
                carry_d = carry;
                if (div_small) begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            ovs_cnt_q  <= '0;
            div_q      <= '0;
            carry_q    <= 1'b0;
            started_q  <= 1'b0;
            err_q      <= 1'b0;
            ovs_tick_q <= 1'b0;
            bit_tick_q <= 1'b0;
            mid_tick_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            ovs_cnt_q  <= ovs_cnt_d;
            div_q      <= div_d;
            carry_q    <= carry_d;
            started_q  <= started_d;
            err_q      <= err_d;
            ovs_tick_q <= ovs_tick_d;
            bit_tick_q <= bit_tick_d;
            mid_tick_q <= mid_tick_d;
        end
    end

    assign ovs_tick = ovs_tick_q;
    assign bit_tick = bit_tick_q;
    assign mid_tick = mid_tick_q;
    assign cnt      = cnt_q;
    assign ovs_cnt  = ovs_cnt_q;
    assign div_err  = err_q;

endmodule
